dm_seq_ctrl: RTL and testbench

// - Upstream source for the display manager: produces prog[2:0], modules[1:0] and data_2[15:0].
// - Conditions four raw Nexys A7 push-buttons and selects program and step size.
// - Runs a tick-paced 16-bit sequence generator whose value is shown on the 7-seg display.

---
 rtl/dm_pkg.sv | 78 +++++++
 rtl/btn_cond.sv | 44 ++++
 rtl/dm_seq_ctrl.sv | 137 +++++++++++++
 tb/tb_dm_seq_ctrl.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/dm_pkg.sv
// Shared types and helpers for the display-manager sequence controller.
// Holds the FSM state type, program opcodes and the per-program next-value functions.
package dm_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StPause
    } state_e;

    typedef enum logic [2:0] {
        ProgAdd     = 3'd0,
        ProgSub     = 3'd1,
        ProgRotl    = 3'd2,
        ProgRotr    = 3'd3,
        ProgLfsr    = 3'd4,
        ProgBcd     = 3'd5,
        ProgJohnson = 3'd6,
        ProgHold    = 3'd7
    } prog_e;

    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    function automatic logic [15:0] rotl16(input logic [15:0] d, input logic [2:0] s);
        logic [31:0] t;
        t = {d, d} << s;
        return t[31:16];
    endfunction

    function automatic logic [15:0] rotr16(input logic [15:0] d, input logic [2:0] s);
        logic [31:0] t;
        t = {d, d} >> s;
        return t[15:0];
    endfunction

    // All-zero is a lock-up state for the LFSR, so it is kicked back to 1.
    function automatic logic [15:0] lfsr_step(input logic [15:0] d);
        logic [15:0] r;
        if (d == 16'h0000) begin
            r = 16'h0001;
        end else if (d[0]) begin
            r = (d >> 1) ^ LFSR_TAPS;
        end else begin
            r = d >> 1;
        end
        return r;
    endfunction

    // Decimal add of a small step across four BCD digits; 9999 wraps through 0000.
    function automatic logic [15:0] bcd_add(input logic [15:0] d, input logic [2:0] s);
        logic [15:0] r;
        logic [4:0]  sum;
        logic [4:0]  carry;
        r     = '0;
        carry = {2'b00, s};
        for (int i = 0; i < 4; i++) begin
            sum = {1'b0, d[4*i +: 4]} + carry;
            if (sum > 5'd9) begin
                r[4*i +: 4] = 4'(sum - 5'd10);
                carry       = 5'd1;
            end else begin
                r[4*i +: 4] = sum[3:0];
                carry       = 5'd0;
            end
        end
        return r;
    endfunction

    function automatic logic [15:0] bcd_sanitize(input logic [15:0] d);
        logic [15:0] r;
        r = '0;
        for (int i = 0; i < 4; i++) begin
            r[4*i +: 4] = (d[4*i +: 4] > 4'd9) ? 4'd0 : d[4*i +: 4];
        end
        return r;
    endfunction

endpackage

// File: rtl/btn_cond.sv
// Raw push-button conditioner: 2-FF synchroniser, counter debounce and a one-cycle
// pulse on each accepted rising level.
module btn_cond #(
    parameter int unsigned DEB_CYCLES = 1_000_000
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_raw,
    output logic pulse
);

    localparam int unsigned CntW = $clog2(DEB_CYCLES + 1);

    logic            sync1_q;
    logic            sync2_q;
    logic            level_q;
    logic [CntW-1:0] cnt_q;

    // The counter tracks consecutive samples that disagree with the accepted level;
    // any agreeing sample restarts it, so short glitches never get through.
    always_ff @(posedge clk) begin
        if (!rst) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            level_q <= 1'b0;
            cnt_q   <= '0;
            pulse   <= 1'b0;
        end else begin
            sync1_q <= btn_raw;
            sync2_q <= sync1_q;
            pulse   <= 1'b0;
            if (sync2_q == level_q) begin
                cnt_q <= '0;
            end else if (cnt_q == CntW'(DEB_CYCLES - 1)) begin
                cnt_q   <= '0;
                level_q <= sync2_q;
                pulse   <= sync2_q;
            end else begin
                cnt_q <= cnt_q + CntW'(1);
            end
        end
    end

endmodule

// File: rtl/dm_seq_ctrl.sv
// Button-driven program/step selection and tick-paced 16-bit sequence generator
// feeding the display manager.
module dm_seq_ctrl
    import dm_pkg::*;
#(
    parameter int unsigned DEB_CYCLES = 1_000_000,
    parameter int unsigned TICK_DIV   = 50_000_000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        btn_start,
    input  logic        btn_stop,
    input  logic        btn_prog,
    input  logic        btn_mod,
    input  logic [15:0] seed,
    output logic [2:0]  prog,
    output logic [1:0]  modules,
    output logic [15:0] data_2,
    output logic        running
);

    localparam int unsigned TickW = $clog2(TICK_DIV + 1);

    logic start_p;
    logic stop_p;
    logic prog_p;
    logic mod_p;

    btn_cond #(.DEB_CYCLES(DEB_CYCLES)) u_btn_start (
        .clk    (clk),
        .rst    (rst),
        .btn_raw(btn_start),
        .pulse  (start_p)
    );

    btn_cond #(.DEB_CYCLES(DEB_CYCLES)) u_btn_stop (
        .clk    (clk),
        .rst    (rst),
        .btn_raw(btn_stop),
        .pulse  (stop_p)
    );

    btn_cond #(.DEB_CYCLES(DEB_CYCLES)) u_btn_prog (
        .clk    (clk),
        .rst    (rst),
        .btn_raw(btn_prog),
        .pulse  (prog_p)
    );

    btn_cond #(.DEB_CYCLES(DEB_CYCLES)) u_btn_mod (
        .clk    (clk),
        .rst    (rst),
        .btn_raw(btn_mod),
        .pulse  (mod_p)
    );

    state_e           state_q;
    logic [TickW-1:0] tick_cnt_q;
    logic             tick;
    logic [2:0]       step;
    logic [15:0]      next_val;
    logic [15:0]      load_val;

    assign tick = (state_q == StRun) && (tick_cnt_q == TickW'(TICK_DIV - 1));

    always_comb begin
        step     = {1'b0, modules} + 3'd1;
        next_val = data_2;
        unique case (prog_e'(prog))
            ProgAdd:     next_val = data_2 + {13'd0, step};
            ProgSub:     next_val = data_2 - {13'd0, step};
            ProgRotl:    next_val = rotl16(data_2, step);
            ProgRotr:    next_val = rotr16(data_2, step);
            ProgLfsr:    next_val = lfsr_step(data_2);
            ProgBcd:     next_val = bcd_add(data_2, step);
            ProgJohnson: next_val = {data_2[14:0], ~data_2[15]};
            ProgHold:    next_val = data_2;
        endcase
    end

    assign load_val = (prog_e'(prog) == ProgBcd) ? bcd_sanitize(seed) : seed;

    // Stop is evaluated ahead of start everywhere so a simultaneous press pauses/exits.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= StIdle;
            prog       <= 3'd0;
            modules    <= 2'd0;
            data_2     <= 16'd0;
            running    <= 1'b0;
            tick_cnt_q <= '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (prog_p) begin
                        prog <= prog + 3'd1;
                    end
                    if (mod_p) begin
                        modules <= modules + 2'd1;
                    end
                    if (start_p && !stop_p) begin
                        data_2     <= load_val;
                        tick_cnt_q <= '0;
                        state_q    <= StRun;
                        running    <= 1'b1;
                    end
                end
                StRun: begin
                    if (tick) begin
                        data_2     <= next_val;
                        tick_cnt_q <= '0;
                    end else begin
                        tick_cnt_q <= tick_cnt_q + TickW'(1);
                    end
                    if (stop_p) begin
                        state_q <= StPause;
                        running <= 1'b0;
                    end
                end
                StPause: begin
                    if (stop_p) begin
                        state_q <= StIdle;
                    end else if (start_p) begin
                        tick_cnt_q <= '0;
                        state_q    <= StRun;
                        running    <= 1'b1;
                    end
                end
                default: begin
                    state_q <= StIdle;
                    running <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dm_seq_ctrl.sv
// Directed bench for dm_seq_ctrl with short debounce and tick periods.
module tb_dm_seq_ctrl;

    localparam int unsigned DEB  = 4;
    localparam int unsigned TDIV = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic        btn_start;
    logic        btn_stop;
    logic        btn_prog;
    logic        btn_mod;
    logic [15:0] seed;
    logic [2:0]  prog;
    logic [1:0]  modules;
    logic [15:0] data_2;
    logic        running;

    dm_seq_ctrl #(
        .DEB_CYCLES(DEB),
        .TICK_DIV  (TDIV)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .btn_start(btn_start),
        .btn_stop (btn_stop),
        .btn_prog (btn_prog),
        .btn_mod  (btn_mod),
        .seed     (seed),
        .prog     (prog),
        .modules  (modules),
        .data_2   (data_2),
        .running  (running)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  prog;
        logic [1:0]  mods;
        logic [15:0] seed;
        logic [15:0] load;
        logic [15:0] t1;
        logic [15:0] t2;
    } vec_t;

    vec_t        vecs[10];
    int          n_checks = 0;
    int          n_errors = 0;
    logic [2:0]  exp_prog = 3'd0;
    logic [1:0]  exp_mod  = 2'd0;
    logic [15:0] snap;
    logic        frozen;

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // which: 0 start, 1 stop, 2 prog, 3 mod
    task automatic press(input int which);
        case (which)
            0: btn_start = 1'b1;
            1: btn_stop  = 1'b1;
            2: btn_prog  = 1'b1;
            default: btn_mod = 1'b1;
        endcase
        step(10);
        btn_start = 1'b0;
        btn_stop  = 1'b0;
        btn_prog  = 1'b0;
        btn_mod   = 1'b0;
        step(10);
    endtask

    task automatic goto_sel(input logic [2:0] p, input logic [1:0] m);
        while (exp_prog != p) begin
            press(2);
            exp_prog = exp_prog + 3'd1;
        end
        while (exp_mod != m) begin
            press(3);
            exp_mod = exp_mod + 2'd1;
        end
        check("sel_prog", {13'd0, prog}, {13'd0, exp_prog});
        check("sel_modules", {14'd0, modules}, {14'd0, exp_mod});
    endtask

    // Holds btn_start until running rises or the budget expires; returns at the entry edge.
    task automatic start_and_wait(input string name);
        logic ok;
        ok        = 1'b0;
        btn_start = 1'b1;
        for (int k = 0; k < 30; k++) begin
            step(1);
            if (running) begin
                ok = 1'b1;
                break;
            end
        end
        check(name, {15'd0, ok}, 16'd1);
    endtask

    initial begin
        vecs[0] = '{3'd0, 2'd1, 16'hFFFE, 16'hFFFE, 16'h0000, 16'h0002};
        vecs[1] = '{3'd1, 2'd1, 16'h0001, 16'h0001, 16'hFFFF, 16'hFFFD};
        vecs[2] = '{3'd2, 2'd3, 16'h1234, 16'h1234, 16'h2341, 16'h3412};
        vecs[3] = '{3'd3, 2'd0, 16'h0001, 16'h0001, 16'h8000, 16'h4000};
        vecs[4] = '{3'd4, 2'd1, 16'h0001, 16'h0001, 16'hB400, 16'h5A00};
        vecs[5] = '{3'd4, 2'd1, 16'h0000, 16'h0000, 16'h0001, 16'hB400};
        vecs[6] = '{3'd5, 2'd1, 16'h9998, 16'h9998, 16'h0000, 16'h0002};
        vecs[7] = '{3'd5, 2'd1, 16'h12A4, 16'h1204, 16'h1206, 16'h1208};
        vecs[8] = '{3'd6, 2'd2, 16'h0000, 16'h0000, 16'h0001, 16'h0003};
        vecs[9] = '{3'd7, 2'd0, 16'hABCD, 16'hABCD, 16'hABCD, 16'hABCD};

        rst       = 1'b0;
        btn_start = 1'b0;
        btn_stop  = 1'b0;
        btn_prog  = 1'b0;
        btn_mod   = 1'b0;
        seed      = 16'h0000;
        step(2);
        check("rst_prog", {13'd0, prog}, 16'd0);
        check("rst_modules", {14'd0, modules}, 16'd0);
        check("rst_data_2", data_2, 16'd0);
        check("rst_running", {15'd0, running}, 16'd0);
        rst = 1'b1;
        step(2);

        // Wrap: 9 prog presses and 5 mod presses
        for (int i = 0; i < 9; i++) press(2);
        exp_prog = 3'd1;
        check("prog_wrap", {13'd0, prog}, 16'd1);
        for (int i = 0; i < 5; i++) press(3);
        exp_mod = 2'd1;
        check("mod_wrap", {14'd0, modules}, 16'd1);

        // Glitches shorter than the debounce window
        btn_prog = 1'b1;
        step(2);
        btn_prog = 1'b0;
        btn_mod  = 1'b1;
        step(2);
        btn_mod = 1'b0;
        step(10);
        check("glitch_prog", {13'd0, prog}, 16'd1);
        check("glitch_mod", {14'd0, modules}, 16'd1);

        for (int v = 0; v < 10; v++) begin
            goto_sel(vecs[v].prog, vecs[v].mods);
            seed = vecs[v].seed;
            start_and_wait("vec_run_start");
            check("vec_load", data_2, vecs[v].load);
            step(7);
            check("vec_pre_tick", data_2, vecs[v].load);
            step(1);
            check("vec_tick1", data_2, vecs[v].t1);
            step(8);
            check("vec_tick2", data_2, vecs[v].t2);
            btn_start = 1'b0;
            press(1);
            check("vec_paused", {15'd0, running}, 16'd0);
            press(1);
        end

        // start+stop together in RUN pauses and freezes data_2
        goto_sel(3'd0, 2'd0);
        seed = 16'h0000;
        start_and_wait("prio_run_start");
        btn_start = 1'b0;
        step(20);
        btn_start = 1'b1;
        btn_stop  = 1'b1;
        begin
            logic ok;
            ok = 1'b0;
            for (int k = 0; k < 30; k++) begin
                step(1);
                if (!running) begin
                    ok = 1'b1;
                    break;
                end
            end
            check("prio_paused", {15'd0, ok}, 16'd1);
        end
        snap = data_2;
        n_checks++;
        if (snap == 16'h0000) begin
            n_errors++;
            $display("FAIL prio_advanced: got %h, expected nonzero", snap);
        end
        btn_start = 1'b0;
        btn_stop  = 1'b0;
        frozen    = 1'b1;
        for (int k = 0; k < 20; k++) begin
            step(1);
            if (data_2 !== snap || running !== 1'b0) frozen = 1'b0;
        end
        check("prio_frozen", {15'd0, frozen}, 16'd1);

        // stop from PAUSE returns to IDLE keeping data; prog press accepted again
        press(1);
        check("idle_data_kept", data_2, snap);
        press(2);
        exp_prog = exp_prog + 3'd1;
        check("idle_prog_accept", {13'd0, prog}, {13'd0, exp_prog});

        // Reset in the middle of a run
        seed = 16'h1234;
        start_and_wait("rst_run_start");
        btn_start = 1'b0;
        step(3);
        rst = 1'b0;
        step(1);
        check("midrst_prog", {13'd0, prog}, 16'd0);
        check("midrst_modules", {14'd0, modules}, 16'd0);
        check("midrst_data_2", data_2, 16'd0);
        check("midrst_running", {15'd0, running}, 16'd0);
        rst = 1'b1;
        step(2);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
